rob_commit: RTL and testbench

Reorder buffer with in-order commit for the out-of-order core. It accepts renamed instructions from dispatch and records their completion from writeback. It retires up to CW oldest completed entries per cycle, driving the commit-side free-list interface: the commit push, new-PR, write-enable and old-PR-to-free lanes. When the oldest entry completed with an exception, it raises a one-cycle rollback and empties itself.

---
 rtl/rob_commit_pkg.sv | 23 ++
 rtl/rob_commit_if.sv | 27 ++
 rtl/rob_commit_entry.sv | 31 +++
 rtl/rob_commit.sv | 91 +++++++++
 tb/tb_rob_commit.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/rob_commit_pkg.sv
// rob_commit_pkg: ROB geometry, entry layout and pointer/index types for the commit slice
package rob_commit_pkg;
    localparam int P_ROB_DEPTH    = 4;
    localparam int N_ROB          = 1 << P_ROB_DEPTH;
    localparam int PRF_AW         = 6;
    localparam int P_ISSUE_WIDTH  = 1;
    localparam int IW             = 1 << P_ISSUE_WIDTH;
    localparam int P_COMMIT_WIDTH = 1;
    localparam int CW             = 1 << P_COMMIT_WIDTH;

    typedef logic [P_ROB_DEPTH:0]   ptr_t;
    typedef logic [P_ROB_DEPTH-1:0] idx_t;
    typedef logic [PRF_AW-1:0]      preg_t;

    typedef struct packed {
        logic  valid;
        logic  done;
        logic  exc;
        logic  prd_we;
        preg_t prd;
        preg_t pfree;
    } rob_entry_t;
endpackage

// File: rtl/rob_commit_if.sv
// rob_commit_if: dispatch, writeback and commit-side free-list lanes of the reorder buffer
interface rob_commit_if;
    import rob_commit_pkg::*;
    logic [IW-1:0]             disp_valid;
    logic [IW-1:0]             disp_prd_we;
    logic [IW*PRF_AW-1:0]      disp_prd;
    logic [IW*PRF_AW-1:0]      disp_pfree;
    logic [IW*P_ROB_DEPTH-1:0] disp_id;
    logic                      rob_stall_req;
    logic [IW-1:0]             wb_valid;
    logic [IW*P_ROB_DEPTH-1:0] wb_id;
    logic [IW-1:0]             wb_exc;
    logic [CW-1:0]             commit_fl_push;
    logic [CW-1:0]             commit_prd_we;
    logic [CW*PRF_AW-1:0]      commit_prd;
    logic [CW*PRF_AW-1:0]      commit_pfree;
    logic                      rollback;

    modport master (
        output disp_valid, disp_prd_we, disp_prd, disp_pfree, wb_valid, wb_id, wb_exc,
        input  disp_id, rob_stall_req, commit_fl_push, commit_prd_we, commit_prd, commit_pfree, rollback
    );
    modport slave (
        input  disp_valid, disp_prd_we, disp_prd, disp_pfree, wb_valid, wb_id, wb_exc,
        output disp_id, rob_stall_req, commit_fl_push, commit_prd_we, commit_prd, commit_pfree, rollback
    );
endinterface

// File: rtl/rob_commit_entry.sv
// rob_entry: one ROB slot; loaded by dispatch, completed by writeback, cleared on commit or flush
module rob_entry
    import rob_commit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       disp_set_i,
    input  rob_entry_t disp_i,
    input  logic       wb_set_i,
    input  logic       wb_exc_i,
    input  logic       clr_i,
    output rob_entry_t ent_o
);
    rob_entry_t ent_q, ent_d;

    always_comb begin
        ent_d = ent_q;
        if (clr_i) ent_d = '0;
        else if (disp_set_i) ent_d = disp_i;
        else if (wb_set_i && ent_q.valid) begin
            ent_d.done = 1'b1;
            ent_d.exc  = ent_q.exc | wb_exc_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ent_q <= '0;
        else ent_q <= ent_d;

    assign ent_o = ent_q;
endmodule

// File: rtl/rob_commit.sv
// rob_commit: reorder buffer with in-order retirement of up to CW completed entries per cycle
module rob_commit
    import rob_commit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    rob_commit_if.slave rob
);
    ptr_t             head_q, head_d, tail_q, tail_d, count;
    idx_t             head_idx;
    idx_t             hidx [CW];
    idx_t             tidx [IW];
    logic [CW-1:0]    push;
    logic [IW-1:0]    go;
    logic [N_ROB-1:0] disp_set, wb_set, wb_exc, clr;
    rob_entry_t       din [N_ROB];
    rob_entry_t       ent [N_ROB];
    logic             ok;

    assign count             = tail_q - head_q;
    assign head_idx          = head_q[P_ROB_DEPTH-1:0];
    assign rob.rob_stall_req = (N_ROB - int'(count)) < IW;
    assign rob.rollback      = ent[head_idx].valid & ent[head_idx].done & ent[head_idx].exc;

    // Each lane retires only if every older lane retires too, so push is a thermometer code
    always_comb begin
        ok = 1'b1;
        for (int k = 0; k < CW; k++) begin
            hidx[k] = head_idx + idx_t'(k);
            ok      = ok & ent[hidx[k]].valid & ent[hidx[k]].done & !ent[hidx[k]].exc;
            push[k] = ok;
            rob.commit_fl_push[k]                  = ok;
            rob.commit_prd_we[k]                   = ok & ent[hidx[k]].prd_we;
            rob.commit_prd[k*PRF_AW +: PRF_AW]     = ent[hidx[k]].prd;
            rob.commit_pfree[k*PRF_AW +: PRF_AW]   = ent[hidx[k]].pfree;
        end
    end

    always_comb begin
        for (int k = 0; k < IW; k++) begin
            tidx[k] = tail_q[P_ROB_DEPTH-1:0] + idx_t'(k);
            go[k]   = rob.disp_valid[k] & !rob.rob_stall_req & !rob.rollback;
            rob.disp_id[k*P_ROB_DEPTH +: P_ROB_DEPTH] = tidx[k];
        end
        for (int i = 0; i < N_ROB; i++) begin
            disp_set[i] = 1'b0;
            din[i]      = '0;
            wb_set[i]   = 1'b0;
            wb_exc[i]   = 1'b0;
            clr[i]      = rob.rollback;
            for (int k = 0; k < IW; k++) begin
                if (go[k] && tidx[k] == idx_t'(i)) begin
                    disp_set[i] = 1'b1;
                    din[i]      = '{valid: 1'b1, done: 1'b0, exc: 1'b0, prd_we: rob.disp_prd_we[k],
                                    prd: rob.disp_prd[k*PRF_AW +: PRF_AW],
                                    pfree: rob.disp_pfree[k*PRF_AW +: PRF_AW]};
                end
                if (rob.wb_valid[k] && rob.wb_id[k*P_ROB_DEPTH +: P_ROB_DEPTH] == idx_t'(i)) begin
                    wb_set[i] = 1'b1;
                    wb_exc[i] = wb_exc[i] | rob.wb_exc[k];
                end
            end
            for (int k = 0; k < CW; k++)
                if (push[k] && hidx[k] == idx_t'(i)) clr[i] = 1'b1;
        end
        tail_d = rob.rollback ? head_q : tail_q + ptr_t'($countones(go));
        head_d = head_q + ptr_t'($countones(push));
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end

    for (genvar i = 0; i < N_ROB; i++) begin : g_ent
        rob_entry u_ent (
            .clk        (clk),
            .rst_n      (rst_n),
            .disp_set_i (disp_set[i]),
            .disp_i     (din[i]),
            .wb_set_i   (wb_set[i]),
            .wb_exc_i   (wb_exc[i]),
            .clr_i      (clr[i]),
            .ent_o      (ent[i])
        );
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed vector table plus hand sequences for wrap, full and async reset
module tb_rob_commit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    rob_commit_if rif();

    rob_commit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rob   (rif)
    );

    typedef struct packed {
        logic [1:0]  dv;
        logic [1:0]  dwe;
        logic [11:0] dprd;
        logic [11:0] dpf;
        logic [1:0]  wv;
        logic [7:0]  wid;
        logic [1:0]  wexc;
        logic [1:0]  push;
        logic [11:0] prd;
        logic [11:0] pf;
        logic [1:0]  pwe;
        logic        rb;
        logic        st;
        logic [7:0]  did;
    } vec_t;

    vec_t v [17];

    function automatic vec_t mk(input logic [1:0] dv, input logic [1:0] dwe, input logic [11:0] dprd,
                                input logic [11:0] dpf, input logic [1:0] wv, input logic [7:0] wid,
                                input logic [1:0] wexc, input logic [1:0] push, input logic [11:0] prd,
                                input logic [11:0] pf, input logic [1:0] pwe, input logic rb,
                                input logic st, input logic [7:0] did);
        return '{dv, dwe, dprd, dpf, wv, wid, wexc, push, prd, pf, pwe, rb, st, did};
    endfunction

    task automatic drive(input logic [1:0] dv, input logic [1:0] dwe, input logic [11:0] dprd,
                         input logic [11:0] dpf, input logic [1:0] wv, input logic [7:0] wid,
                         input logic [1:0] wexc);
        rif.disp_valid  = dv;
        rif.disp_prd_we = dwe;
        rif.disp_prd    = dprd;
        rif.disp_pfree  = dpf;
        rif.wb_valid    = wv;
        rif.wb_id       = wid;
        rif.wb_exc      = wexc;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic chk_commit(input string n, input logic [1:0] push, input logic [11:0] prd,
                              input logic [11:0] pf, input logic [1:0] pwe);
        logic [11:0] m;
        m = {{6{push[1]}}, {6{push[0]}}};
        chk({n, ".push"}, 32'(rif.commit_fl_push), 32'(push));
        if (push != 2'b00) begin
            chk({n, ".prd"}, 32'(rif.commit_prd & m), 32'(prd & m));
            chk({n, ".pfree"}, 32'(rif.commit_pfree & m), 32'(pf & m));
            chk({n, ".prd_we"}, 32'(rif.commit_prd_we & push), 32'(pwe & push));
        end
    endtask

    task automatic chk_state(input string n, input logic rb, input logic st, input logic [7:0] did);
        chk({n, ".rollback"}, 32'(rif.rollback), 32'(rb));
        chk({n, ".stall"}, 32'(rif.rob_stall_req), 32'(st));
        chk({n, ".disp_id"}, 32'(rif.disp_id), 32'(did));
    endtask

    initial begin
        v[0]  = mk(2'b11, 2'b11, {6'd7, 6'd6}, {6'd2, 6'd1}, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h10);
        v[1]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b11, 8'h10, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h32);
        v[2]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00, 2'b11, {6'd7, 6'd6}, {6'd2, 6'd1}, 2'b11, 1'b0, 1'b0, 8'h32);
        v[3]  = mk(2'b11, 2'b01, {6'd11, 6'd10}, {6'd4, 6'd3}, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h32);
        v[4]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b01, 8'h03, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h54);
        v[5]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b10, 8'h20, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h54);
        v[6]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00, 2'b11, {6'd11, 6'd10}, {6'd4, 6'd3}, 2'b01, 1'b0, 1'b0, 8'h54);
        v[7]  = mk(2'b11, 2'b11, {6'd21, 6'd20}, {6'd6, 6'd5}, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h54);
        v[8]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b01, 8'h04, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h76);
        v[9]  = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b01, 8'h05, 2'b00, 2'b01, {6'd0, 6'd20}, {6'd0, 6'd5}, 2'b01, 1'b0, 1'b0, 8'h76);
        v[10] = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00, 2'b01, {6'd0, 6'd21}, {6'd0, 6'd6}, 2'b01, 1'b0, 1'b0, 8'h76);
        v[11] = mk(2'b11, 2'b11, {6'd31, 6'd30}, {6'd8, 6'd7}, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h76);
        v[12] = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b11, 8'h76, 2'b01, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h98);
        v[13] = mk(2'b11, 2'b11, {6'd33, 6'd32}, {6'd1, 6'd1}, 2'b11, 8'h76, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b1, 1'b0, 8'h98);
        v[14] = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h76);
        v[15] = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b11, 8'h76, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h76);
        v[16] = mk(2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 8'h00, 2'b00, 2'b00, 12'd0, 12'd0, 2'b00, 1'b0, 1'b0, 8'h76);

        idle();
        repeat (2) tick();
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            chk_commit($sformatf("v%0d", i), v[i].push, v[i].prd, v[i].pf, v[i].pwe);
            chk_state($sformatf("v%0d", i), v[i].rb, v[i].st, v[i].did);
            drive(v[i].dv, v[i].dwe, v[i].dprd, v[i].dpf, v[i].wv, v[i].wid, v[i].wexc);
            tick();
        end

        // move head to an odd index so later commit pairs straddle entry 15 -> 0
        drive(2'b01, 2'b01, {6'd0, 6'd40}, {6'd0, 6'd9}, 2'b00, 8'h00, 2'b00);
        tick();
        drive(2'b00, 2'b00, 12'd0, 12'd0, 2'b01, 8'h06, 2'b00);
        tick();
        chk_commit("odd", 2'b01, {6'd0, 6'd40}, {6'd0, 6'd9}, 2'b01);
        idle();
        tick();

        for (int j = 0; j < 8; j++) begin
            logic [3:0] e0, e1;
            e0 = 4'(7 + 2 * j);
            e1 = 4'(8 + 2 * j);
            chk_state($sformatf("fill%0d", j), 1'b0, 1'b0, {e1, e0});
            drive(2'b11, 2'b11, {2'b10, e1, 2'b10, e0}, {2'b00, e1, 2'b00, e0}, 2'b00, 8'h00, 2'b00);
            tick();
        end

        chk_state("full", 1'b0, 1'b1, 8'h87);
        drive(2'b11, 2'b11, {6'd60, 6'd61}, {6'd60, 6'd61}, 2'b11, 8'h87, 2'b00);
        tick();
        chk_state("full_commit", 1'b0, 1'b1, 8'h87);
        chk_commit("full_commit", 2'b11, {6'd40, 6'd39}, {6'd8, 6'd7}, 2'b11);
        drive(2'b11, 2'b11, {6'd62, 6'd63}, {6'd62, 6'd63}, 2'b11, 8'hA9, 2'b00);
        tick();
        chk_state("release", 1'b0, 1'b0, 8'h87);
        chk_commit("release", 2'b11, {6'd42, 6'd41}, {6'd10, 6'd9}, 2'b11);
        drive(2'b11, 2'b11, {6'd51, 6'd50}, {6'd21, 6'd20}, 2'b11, 8'hCB, 2'b00);
        tick();

        for (int p = 0; p < 6; p++) begin
            logic [3:0] h, h1, h2, h3;
            h  = 4'(11 + 2 * p);
            h1 = h + 4'd1;
            h2 = h + 4'd2;
            h3 = h + 4'd3;
            chk_state($sformatf("drain%0d", p), 1'b0, 1'b0, 8'hA9);
            chk_commit($sformatf("drain%0d", p), 2'b11, {2'b10, h1, 2'b10, h}, {2'b00, h1, 2'b00, h}, 2'b11);
            drive(2'b00, 2'b00, 12'd0, 12'd0, 2'b11, {h3, h2}, 2'b00);
            tick();
        end
        chk_commit("wrapped", 2'b11, {6'd51, 6'd50}, {6'd21, 6'd20}, 2'b11);
        idle();
        tick();
        chk_commit("empty", 2'b00, 12'd0, 12'd0, 2'b00);
        chk_state("empty", 1'b0, 1'b0, 8'hA9);

        drive(2'b11, 2'b11, {6'd2, 6'd1}, {6'd4, 6'd3}, 2'b00, 8'h00, 2'b00);
        tick();
        drive(2'b11, 2'b11, {6'd12, 6'd11}, {6'd14, 6'd13}, 2'b00, 8'h00, 2'b00);
        tick();
        drive(2'b01, 2'b01, {6'd0, 6'd15}, {6'd0, 6'd16}, 2'b11, 8'hA9, 2'b00);
        tick();
        chk_commit("pre_rst", 2'b11, {6'd2, 6'd1}, {6'd4, 6'd3}, 2'b11);
        idle();
        #2 rst_n = 1'b0;
        #1;
        chk_commit("in_rst", 2'b00, 12'd0, 12'd0, 2'b00);
        chk_state("in_rst", 1'b0, 1'b0, 8'h10);
        tick();
        rst_n = 1'b1;
        chk_commit("post_rst", 2'b00, 12'd0, 12'd0, 2'b00);
        chk_state("post_rst", 1'b0, 1'b0, 8'h10);
        drive(2'b01, 2'b01, {6'd0, 6'd5}, {6'd0, 6'd3}, 2'b00, 8'h00, 2'b00);
        tick();
        drive(2'b00, 2'b00, 12'd0, 12'd0, 2'b01, 8'h00, 2'b00);
        tick();
        chk_commit("post_rst_commit", 2'b01, {6'd0, 6'd5}, {6'd0, 6'd3}, 2'b01);
        idle();
        tick();
        chk_state("post_rst_done", 1'b0, 1'b0, 8'h21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
